// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem
// Word-organised AHB-lite memory responder. Accepts byte, halfword and word
// transfers, optionally stretches every OKAY data phase by a fixed number of
// wait states, and answers illegal transfers with the two-cycle ERROR
// response. Memory contents survive reset; only the bus-facing state clears.

module ahb_lite_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [1:0]            htrans,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);

    // Index width of the word array; a one-word memory still needs one bit.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Data-phase states.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    // Counter preload: the WAIT state is left once the counter reads zero,
    // so loading WAIT_STATES-1 yields exactly WAIT_STATES stalled cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Highest legal word index + 1, expressed at the width of the word address.
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [3:0]       wait_cnt;
    logic [3:0]       wait_cnt_next;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             write_q;

    logic             accept_window;
    logic             accept;
    logic             size_err;
    logic             align_err;
    logic             range_err;
    logic             xfer_err;
    logic [3:0]       byte_en;

    // hburst is deliberately ignored (every beat stands alone) and htrans[0]
    // only separates SEQ from NONSEQ, which this slave treats identically.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, htrans[0]};

    // A new address phase can only complete when this slave is driving
    // hreadyout high, i.e. outside WAIT and ERR1.
    assign accept_window = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept        = hsel && hready && htrans[1] && accept_window;

    // Legality of the transfer currently in its address phase.
    always_comb begin
        size_err  = (hsize > 3'd2);
        align_err = ((hsize == 3'd1) && haddr[0]) ||
                    ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
        range_err = (haddr[ADDR_WIDTH-1:2] >= DEPTH_LIMIT);
        xfer_err  = size_err || align_err || range_err;
    end

    // Next-state and wait-counter logic for the data-phase sequencer.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ST_DATA;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                state_next = ST_ERR2;
            end
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    if (xfer_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and wait counter; reset drops any transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Address-phase capture of index, byte lane, size and direction.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= haddr[IDX_W+1:2];
            lane_q  <= haddr[1:0];
            size_q  <= hsize[1:0];
            write_q <= hwrite;
        end
    end

    // Little-endian byte-lane enables for the captured size and offset.
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            2'd0:    byte_en[lane_q] = 1'b1;
            2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Memory write on the closing edge of a write DATA cycle; no reset so
    // the contents survive, and a reset that is asserted suppresses the write.
    always_ff @(posedge hclk) begin
        if (!hreset && (state == ST_DATA) && write_q) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[idx_q][8*k +: 8] <= hwdata[8*k +: 8];
                end
            end
        end
    end

    // Bus-facing outputs are decoded straight from the state so that reset
    // forces them to their idle values without waiting for a clock.
    assign hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
    assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);
    assign hrdata    = ((state == ST_DATA) && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// tb_ahb_lite_slave_mem
// Directed bench for the AHB-lite memory slave. Three instances with 0, 3 and
// 2 wait states share one bus; a select variable picks which one the bench
// is mastering. hready follows the selected slave's hreadyout like a real
// interconnect, with an override to force it low.

module tb_ahb_lite_slave_mem;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_BUSY = 2'd1;
    localparam logic [1:0] T_NSEQ = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;
    localparam logic [2:0] SZ_B   = 3'd0;
    localparam logic [2:0] SZ_H   = 3'd1;
    localparam logic [2:0] SZ_W   = 3'd2;

    // One bus cycle: address-phase inputs, hwdata for the previous transfer
    // and the outputs expected during that same cycle.
    typedef struct {
        logic        sel;
        logic        rdy_low;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rdy;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        hclk;
    logic        hreset;
    logic        hsel_bus;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready_low;
    logic        hready;
    int          sel_dut;

    logic        hsel0, hsel3, hsel2;
    logic [31:0] rdata0, rdata3, rdata2;
    logic        rdy0, rdy3, rdy2;
    logic        resp0, resp3, resp2;

    logic        cur_rdy;
    logic        cur_resp;
    logic [31:0] cur_rdata;

    int          checks;
    int          errors;
    vec_t        vecs[$];

    assign hsel0 = hsel_bus && (sel_dut == 0);
    assign hsel3 = hsel_bus && (sel_dut == 1);
    assign hsel2 = hsel_bus && (sel_dut == 2);

    ahb_lite_slave_mem #(.WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
        .hready(hready), .hwdata(hwdata), .hrdata(rdata0),
        .hreadyout(rdy0), .hresp(resp0)
    );

    ahb_lite_slave_mem #(.WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
        .hready(hready), .hwdata(hwdata), .hrdata(rdata3),
        .hreadyout(rdy3), .hresp(resp3)
    );

    ahb_lite_slave_mem #(.WAIT_STATES(2)) u_ws2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .htrans(htrans),
        .hready(hready), .hwdata(hwdata), .hrdata(rdata2),
        .hreadyout(rdy2), .hresp(resp2)
    );

    // Route the selected slave's response back as the bus response.
    always_comb begin
        case (sel_dut)
            1: begin cur_rdy = rdy3; cur_resp = resp3; cur_rdata = rdata3; end
            2: begin cur_rdy = rdy2; cur_resp = resp2; cur_rdata = rdata2; end
            default: begin cur_rdy = rdy0; cur_resp = resp0; cur_rdata = rdata0; end
        endcase
    end

    assign hready = hready_low ? 1'b0 : cur_rdy;

    // Free-running bus clock.
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    // Record one table row.
    task automatic addVec(input logic sel, input logic low, input logic [1:0] tr,
                          input logic wr, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic er, input logic eresp,
                          input logic [31:0] erd);
        vec_t v;
        v.sel = sel; v.rdy_low = low; v.trans = tr; v.wr = wr; v.size = sz;
        v.addr = a; v.wdata = wd; v.exp_rdy = er; v.exp_resp = eresp;
        v.exp_rdata = erd;
        vecs.push_back(v);
    endtask

    // Drive one cycle's worth of bus inputs.
    task automatic applyStimulus(input vec_t v);
        hsel_bus   = v.sel;
        hready_low = v.rdy_low;
        htrans     = v.trans;
        hwrite     = v.wr;
        hsize      = v.size;
        haddr      = v.addr;
        hwdata     = v.wdata;
    endtask

    // Compare the selected slave's outputs against expectations.
    task automatic checkOutput(input string tag, input logic exp_rdy,
                               input logic exp_resp, input logic [31:0] exp_rdata);
        checks++;
        if (cur_rdy !== exp_rdy) begin
            errors++;
            $display("[TB] FAIL %s hreadyout got %b want %b", tag, cur_rdy, exp_rdy);
        end
        checks++;
        if (cur_resp !== exp_resp) begin
            errors++;
            $display("[TB] FAIL %s hresp got %b want %b", tag, cur_resp, exp_resp);
        end
        checks++;
        if (cur_rdata !== exp_rdata) begin
            errors++;
            $display("[TB] FAIL %s hrdata got %h want %h", tag, cur_rdata, exp_rdata);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Set the address phase of a single transfer.
    task automatic drive(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a);
        hsel_bus = 1'b1;
        htrans   = tr;
        hwrite   = wr;
        hsize    = sz;
        haddr    = a;
    endtask

    // Main directed sequence.
    initial begin
        checks = 0;
        errors = 0;

        // Zero-wait table: pipelined writes/reads, lanes, non-transfers, errors.
        addVec(1,0,T_NSEQ,1,SZ_W,32'h10, 32'h0,        1,0,32'h0);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h10, 32'hDEADBEEF, 1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'hDEADBEEF);
        addVec(1,0,T_NSEQ,1,SZ_W,32'h20, 32'h0,        1,0,32'h0);
        addVec(1,0,T_NSEQ,1,SZ_B,32'h22, 32'h00000000, 1,0,32'h0);
        addVec(1,0,T_NSEQ,1,SZ_H,32'h20, 32'hABABABAB, 1,0,32'h0);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h20, 32'h12341234, 1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'h00AB1234);
        addVec(1,0,T_NSEQ,1,SZ_H,32'h22, 32'h0,        1,0,32'h0);
        addVec(1,0,T_SEQ, 1,SZ_B,32'h21, 32'h56785678, 1,0,32'h0);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h20, 32'h9A9A9A9A, 1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'h56789A34);
        addVec(1,0,T_BUSY,1,SZ_W,32'h10, 32'h0,        1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'h0);
        addVec(0,0,T_NSEQ,1,SZ_W,32'h10, 32'h0,        1,0,32'h0);
        addVec(1,1,T_NSEQ,1,SZ_W,32'h10, 32'hFFFFFFFF, 1,0,32'h0);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h10, 32'hFFFFFFFF, 1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'hDEADBEEF);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h400,32'h0,        1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        0,1,32'h0);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h2,  32'h0,        1,1,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        0,1,32'h0);
        addVec(1,0,T_NSEQ,1,3'd3,32'h10, 32'h0,        1,1,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0BADF00D, 0,1,32'h0);
        addVec(1,0,T_NSEQ,1,SZ_H,32'h11, 32'h0BADF00D, 1,1,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0BADF00D, 0,1,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0BADF00D, 1,1,32'h0);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h10, 32'h0,        1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'hDEADBEEF);
        addVec(1,0,T_NSEQ,1,SZ_W,32'h3FC,32'h0,        1,0,32'h0);
        addVec(1,0,T_SEQ, 0,SZ_W,32'h3FC,32'hCAFEF00D, 1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'hCAFEF00D);
        addVec(1,0,T_NSEQ,0,SZ_W,32'h20, 32'h0,        1,0,32'h0);
        addVec(1,0,T_IDLE,0,SZ_W,32'h0,  32'h0,        1,0,32'h56789A34);

        hreset     = 1'b1;
        hsel_bus   = 1'b0;
        haddr      = 32'h0;
        hwrite     = 1'b0;
        hsize      = SZ_W;
        hburst     = 3'b001;
        htrans     = T_IDLE;
        hwdata     = 32'h0;
        hready_low = 1'b0;
        sel_dut    = 0;

        repeat (2) @(posedge hclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            sel_dut = d;
            #1;
            checkOutput($sformatf("reset dut%0d", d), 1'b1, 1'b0, 32'h0);
        end
        hreset  = 1'b0;
        sel_dut = 0;
        step();

        $display("[TB] zero-wait table, %0d rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge hclk);
            checkOutput($sformatf("row%0d", i), vecs[i].exp_rdy, vecs[i].exp_resp,
                        vecs[i].exp_rdata);
            step();
        end
        hready_low = 1'b0;

        // Three wait states: write with hwdata churning during waits, then a
        // pipelined read of the same word.
        $display("[TB] three wait states");
        sel_dut = 1;
        drive(T_NSEQ, 1'b1, SZ_W, 32'h0);
        hwdata = 32'h0;
        @(negedge hclk);
        checkOutput("ws3 addr", 1'b1, 1'b0, 32'h0);
        step();
        htrans = T_IDLE;
        for (int i = 0; i < 3; i++) begin
            hwdata = 32'hFFFF0000 + 32'(i);
            @(negedge hclk);
            checkOutput($sformatf("ws3 wr wait%0d", i), 1'b0, 1'b0, 32'h0);
            step();
        end
        hwdata = 32'h13579BDF;
        drive(T_NSEQ, 1'b0, SZ_W, 32'h0);
        @(negedge hclk);
        checkOutput("ws3 wr data", 1'b1, 1'b0, 32'h0);
        step();
        htrans = T_IDLE;
        hwdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            checkOutput($sformatf("ws3 rd wait%0d", i), 1'b0, 1'b0, 32'h0);
            step();
        end
        @(negedge hclk);
        checkOutput("ws3 rd data", 1'b1, 1'b0, 32'h13579BDF);
        step();
        @(negedge hclk);
        checkOutput("ws3 idle", 1'b1, 1'b0, 32'h0);
        step();

        // Two wait states: seed a word, then reset in the middle of a second
        // write and confirm the seed survives.
        $display("[TB] reset during wait");
        sel_dut = 2;
        drive(T_NSEQ, 1'b1, SZ_W, 32'h8);
        @(negedge hclk);
        checkOutput("ws2 seed addr", 1'b1, 1'b0, 32'h0);
        step();
        htrans = T_IDLE;
        hwdata = 32'h11111111;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            checkOutput($sformatf("ws2 seed wait%0d", i), 1'b0, 1'b0, 32'h0);
            step();
        end
        @(negedge hclk);
        checkOutput("ws2 seed data", 1'b1, 1'b0, 32'h0);
        step();
        drive(T_NSEQ, 1'b1, SZ_W, 32'h8);
        hwdata = 32'h22222222;
        @(negedge hclk);
        checkOutput("ws2 wr addr", 1'b1, 1'b0, 32'h0);
        step();
        htrans = T_IDLE;
        #2;
        checkOutput("ws2 wr wait", 1'b0, 1'b0, 32'h0);
        hreset = 1'b1;
        #1;
        checkOutput("ws2 async reset", 1'b1, 1'b0, 32'h0);
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        checkOutput("ws2 after reset", 1'b1, 1'b0, 32'h0);
        step();
        drive(T_NSEQ, 1'b0, SZ_W, 32'h8);
        @(negedge hclk);
        checkOutput("ws2 rd addr", 1'b1, 1'b0, 32'h0);
        step();
        htrans = T_IDLE;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            checkOutput($sformatf("ws2 rd wait%0d", i), 1'b0, 1'b0, 32'h0);
            step();
        end
        @(negedge hclk);
        checkOutput("ws2 rd data", 1'b1, 1'b0, 32'h11111111);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_slave_mem.md
Name: ahb_lite_slave_mem

Overview:
- AHB-lite responder: a word-organised memory slave that answers transfers from the team's AHB master driver.
- Sits on the far side of the AHB interface and serves as the DUT for the driver and monitor agents.
- Supports byte, halfword and word accesses, programmable wait states, and the two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 32, width of haddr.
- DATA_WIDTH, 32, width of hwdata/hrdata; fixed at 32 for this revision.
- MEM_DEPTH, 256, number of 32-bit words; word index = haddr[ADDR_WIDTH-1:2].
- WAIT_STATES, 0, extra data-phase cycles (hreadyout=0) inserted on every OKAY transfer; legal range 0..15.

Ports:
- hclk  input  1  bus clock, all state on rising edge.
- hreset  input  1  asynchronous, active-high reset.
- hsel  input  1  slave select from decoder.
- haddr  input  ADDR_WIDTH  transfer address.
- hwrite  input  1  1=write, 0=read.
- hsize  input  3  0=byte, 1=halfword, 2=word; other values are errors.
- hburst  input  3  accepted and ignored; every beat is handled as an independent transfer.
- htrans  input  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- hready  input  1  bus-level ready (hreadyin).
- hwdata  input  DATA_WIDTH  write data, sampled in the data phase.
- hrdata  output  DATA_WIDTH  read data.
- hreadyout  output  1  slave ready.
- hresp  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async assert, sync release): state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, captured address-phase registers cleared. Memory contents are not reset.
- Reset mid-transfer: return to IDLE immediately. A pending write is discarded with no memory update.
- Address phase accept: hsel & hready & htrans[1] on a rising edge. Capture addr, hwrite, hsize.
  - IDLE or BUSY with hsel=1, or any cycle with hsel=0 or hready=0: no capture; next cycle is a zero-wait OKAY (hreadyout=1, hresp=0).
- Error check at accept. ERROR if any of:
  - hsize>2;
  - hsize=1 and haddr[0]=1;
  - hsize=2 and haddr[1:0]!=0;
  - word index >= MEM_DEPTH.
- States:
  - IDLE: hreadyout=1, hresp=0. An accepted OKAY transfer goes to WAIT if WAIT_STATES>0, else DATA. An accepted error goes to ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter loaded with WAIT_STATES-1 at accept, decrements each cycle; move to DATA when it reaches 0. Exactly WAIT_STATES cycles are spent here.
  - DATA: hreadyout=1, hresp=0; final data-phase cycle.
    - Write: on the closing edge, update only the byte lanes selected by hsize and addr[1:0] (little-endian, byte lane k = bits 8k+7:8k) from hwdata.
    - Read: hrdata = full 32-bit memory word at the captured index, driven combinationally. The master selects lanes.
    - A new accepted transfer in the same cycle (pipelining) goes to WAIT/DATA/ERR1 as above; otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=1; always followed by ERR2.
  - ERR2: hreadyout=1, hresp=1. No memory write. A transfer accepted here is processed normally. The master may instead drive IDLE.
- hrdata = 0 in every cycle other than a read DATA cycle.
- Read-after-write: a write's DATA cycle updates memory on its closing edge. A read whose DATA cycle immediately follows returns the new value; no forwarding path is needed.
- Back-to-back zero-wait transfers sustain one transfer per cycle.
- hwdata is only used in the DATA cycle. hwdata values during WAIT are ignored.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> read data phase shows hreadyout=1, hresp=0, hrdata=0xDEADBEEF one cycle after the write data phase.
- Byte/halfword lanes: write word 0x00000000 @0x20; write byte 0xAB (hwdata=0xABABABAB, hsize=0) @0x22; write halfword 0x1234 (hwdata=0x12341234) @0x20; read @0x20 -> 0x00AB1234.
- WAIT_STATES=3: single read @0x0 -> exactly 3 cycles with hreadyout=0 after the address phase, then 1 cycle hreadyout=1 with data. Changing hwdata during wait cycles of a write has no effect on stored data.
- Errors: read @0x400 with MEM_DEPTH=256, then hsize=2 @0x2, then hsize=3 -> each gives cycle 1 hreadyout=0/hresp=1 and cycle 2 hreadyout=1/hresp=1; memory unchanged (read @0x0 returns the prior value).
- Non-transfers: htrans=IDLE, htrans=BUSY, hsel=0, and hready=0 during a NONSEQ -> no capture, hreadyout=1, hresp=0, hrdata=0, memory unchanged.
- Reset mid-op (WAIT_STATES=2): assert hreset during WAIT of a write to 0x8 holding prior 0x11111111 -> outputs return to reset values asynchronously; after release, read @0x8 returns 0x11111111.
